readrf_multich: RTL and testbench

Parametrised successor to the fixed four-channel RF sample reader used by the beamforming path. Holds one pre-loaded RF trace per receive channel in on-chip sample memory. Steps through a programmable-length frame, one sample index per `inc_count` request, and presents all channels' samples for that index in parallel. Each output word carries a valid strobe, the sample index it belongs to, and an end-of-frame marker, ready for the delay/sum stage.

---
 rtl/readrf_multich.sv | 120 ++++++++++++
 tb/tb_readrf_multich.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/readrf_multich.sv
// Multi-channel RF trace reader: steps a programmable-length frame and presents
// every channel's sample for the current index in parallel.
// Optional feature macro: READRF_WRAP_EN (continuous replay instead of stopping at frame end).
module readrf_multich #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned ADDR_W    = $clog2(DEPTH),
    parameter string       INIT_FILE = "rf_data.hex"
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_W:0]          frame_len,
    input  logic                     inc_count,
    output logic [NUM_CH*DATA_W-1:0] vals,
    output logic                     vals_valid,
    output logic [ADDR_W-1:0]        sample_idx,
    output logic                     frame_done,
    output logic                     busy
);

    localparam int unsigned CNT_W     = ADDR_W + 1;
    localparam int unsigned MEM_WORDS = NUM_CH * DEPTH;
    localparam int unsigned MEM_AW    = $clog2(MEM_WORDS);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [CNT_W-1:0]          len_q, len_d;
    logic [CNT_W-1:0]          len_sel_c;
    logic                      accept_c;
    logic                      last_c;

    logic [NUM_CH*DATA_W-1:0]  vals_q;
    logic                      vals_valid_q;
    logic [ADDR_W-1:0]         sample_idx_q;
    logic                      frame_done_q;
    logic                      busy_q;

    // Channel-major sample store: word c*DEPTH + i is channel c, sample i; contents loaded by the environment.
    logic [DATA_W-1:0]         mem_q [MEM_WORDS];

    // Out-of-range or zero frame length means a full trace.
    assign len_sel_c = ((frame_len == '0) || (frame_len > DEPTH_C)) ? DEPTH_C : frame_len;
    assign last_c    = (count_q == (len_q - CNT_W'(1)));

    // Next-state and counter control; start always wins over a same-cycle request.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        len_d    = len_q;
        accept_c = 1'b0;

        if (start) begin
            state_d = S_RUN;
            count_d = '0;
            len_d   = len_sel_c;
        end else if ((state_q == S_RUN) && inc_count) begin
            accept_c = 1'b1;
            if (last_c) begin
`ifdef READRF_WRAP_EN
                count_d = '0;
`else
                count_d = count_q + CNT_W'(1);
                state_d = S_DONE;
`endif
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            len_q   <= DEPTH_C;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
        end
    end

    // Synchronous read doubles as the output holding register for vals.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vals_q       <= '0;
            vals_valid_q <= 1'b0;
            sample_idx_q <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            vals_valid_q <= accept_c;
            frame_done_q <= accept_c && last_c;
            busy_q       <= (state_d == S_RUN);
            if (accept_c) begin
                sample_idx_q <= count_q[ADDR_W-1:0];
                for (int c = 0; c < int'(NUM_CH); c++) begin
                    vals_q[c*DATA_W +: DATA_W] <=
                        mem_q[MEM_AW'(c * int'(DEPTH)) + MEM_AW'(count_q[ADDR_W-1:0])];
                end
            end
        end
    end

    assign vals       = vals_q;
    assign vals_valid = vals_valid_q;
    assign sample_idx = sample_idx_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_readrf_multich.sv
// Directed self-checking bench for readrf_multich (DEPTH=16, four 16-bit channels).
module tb_readrf_multich;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b1;
    logic                     start = 1'b0;
    logic [ADDR_W:0]          frame_len = '0;
    logic                     inc_count = 1'b0;
    logic [NUM_CH*DATA_W-1:0] vals;
    logic                     vals_valid;
    logic [ADDR_W-1:0]        sample_idx;
    logic                     frame_done;
    logic                     busy;

    int n_checks = 0;
    int n_fail   = 0;

    readrf_multich #(
        .NUM_CH   (NUM_CH),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .INIT_FILE("")
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .start     (start),
        .frame_len (frame_len),
        .inc_count (inc_count),
        .vals      (vals),
        .vals_valid(vals_valid),
        .sample_idx(sample_idx),
        .frame_done(frame_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [NUM_CH*DATA_W-1:0] exp_vals(input int i);
        logic [NUM_CH*DATA_W-1:0] v;
        v = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            v[c*DATA_W +: DATA_W] = 16'((c << 12) | i);
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_checks++; if (vals !== '0) begin n_fail++; $display("FAIL reset_vals got %h want 0", vals); end
        n_checks++; if (vals_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", vals_valid); end
        n_checks++; if (sample_idx !== '0) begin n_fail++; $display("FAIL reset_idx got %0d want 0", sample_idx); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", frame_done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        tick();
        tick();
        rst_n = 1'b1;
        inc_count = 1'b1;
        tick();
        inc_count = 1'b0;
        n_checks++; if (vals_valid !== 1'b0) begin n_fail++; $display("FAIL idle_inc_ignored got %b want 0", vals_valid); end
    endtask

    task automatic test_basic();
        frame_len = 5'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", busy); end
        n_checks++; if (vals_valid !== 1'b0) begin n_fail++; $display("FAIL basic_start_valid got %b want 0", vals_valid); end
        inc_count = 1'b1;
        tick();
        inc_count = 1'b0;
        n_checks++; if (vals_valid !== 1'b1) begin n_fail++; $display("FAIL basic_s1_valid got %b want 1", vals_valid); end
        n_checks++; if (vals !== 64'h3000_2000_1000_0000) begin n_fail++; $display("FAIL basic_s1_vals got %h want 3000200010000000", vals); end
        n_checks++; if (sample_idx !== 4'd0) begin n_fail++; $display("FAIL basic_s1_idx got %0d want 0", sample_idx); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL basic_s1_done got %b want 0", frame_done); end
        tick();
        n_checks++; if (vals_valid !== 1'b0) begin n_fail++; $display("FAIL basic_gap_valid got %b want 0", vals_valid); end
        n_checks++; if (vals !== 64'h3000_2000_1000_0000) begin n_fail++; $display("FAIL basic_gap_hold got %h want 3000200010000000", vals); end
        inc_count = 1'b1;
        tick();
        inc_count = 1'b0;
        n_checks++; if (vals_valid !== 1'b1) begin n_fail++; $display("FAIL basic_s2_valid got %b want 1", vals_valid); end
        n_checks++; if (vals !== 64'h3001_2001_1001_0001) begin n_fail++; $display("FAIL basic_s2_vals got %h want 3001200110010001", vals); end
        n_checks++; if (sample_idx !== 4'd1) begin n_fail++; $display("FAIL basic_s2_idx got %0d want 1", sample_idx); end
    endtask

    // Start a frame, hold inc_count for 'cycles' edges and expect exp_n strobes.
    task automatic test_frame(input int fl, input int exp_n, input int cycles);
        int strobes;
        strobes = 0;
        frame_len = 5'(fl);
        start = 1'b1;
        tick();
        start = 1'b0;
        inc_count = 1'b1;
        for (int k = 0; k < cycles; k++) begin
            tick();
            if (vals_valid === 1'b1) strobes++;
            n_checks++; if (vals_valid !== (k < exp_n)) begin n_fail++; $display("FAIL frame%0d_valid k=%0d got %b want %b", fl, k, vals_valid, (k < exp_n)); end
            n_checks++; if (busy !== (k < exp_n - 1)) begin n_fail++; $display("FAIL frame%0d_busy k=%0d got %b want %b", fl, k, busy, (k < exp_n - 1)); end
            if (k < exp_n) begin
                n_checks++; if (sample_idx !== 4'(k)) begin n_fail++; $display("FAIL frame%0d_idx k=%0d got %0d want %0d", fl, k, sample_idx, k); end
                n_checks++; if (vals !== exp_vals(k)) begin n_fail++; $display("FAIL frame%0d_vals k=%0d got %h want %h", fl, k, vals, exp_vals(k)); end
                n_checks++; if (frame_done !== (k == exp_n - 1)) begin n_fail++; $display("FAIL frame%0d_done k=%0d got %b want %b", fl, k, frame_done, (k == exp_n - 1)); end
            end else begin
                n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL frame%0d_done_after k=%0d got %b want 0", fl, k, frame_done); end
            end
        end
        inc_count = 1'b0;
        n_checks++; if (strobes !== exp_n) begin n_fail++; $display("FAIL frame%0d_count got %0d want %0d", fl, strobes, exp_n); end
    endtask

    task automatic test_restart();
        frame_len = 5'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        inc_count = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        n_checks++; if (vals_valid !== 1'b1 || sample_idx !== 4'd4) begin n_fail++; $display("FAIL restart_inflight got v=%b idx=%0d want v=1 idx=4", vals_valid, sample_idx); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL restart_inflight_done got %b want 0", frame_done); end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (vals_valid !== 1'b0) begin n_fail++; $display("FAIL restart_drop got %b want 0", vals_valid); end
        n_checks++; if (vals !== exp_vals(4)) begin n_fail++; $display("FAIL restart_hold got %h want %h", vals, exp_vals(4)); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy got %b want 1", busy); end
        tick();
        inc_count = 1'b0;
        n_checks++; if (vals_valid !== 1'b1 || sample_idx !== 4'd0) begin n_fail++; $display("FAIL restart_idx0 got v=%b idx=%0d want v=1 idx=0", vals_valid, sample_idx); end
        n_checks++; if (vals !== exp_vals(0)) begin n_fail++; $display("FAIL restart_vals got %h want %h", vals, exp_vals(0)); end
    endtask

    task automatic test_reset_mid();
        frame_len = 5'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        inc_count = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (vals !== '0 || sample_idx !== '0) begin n_fail++; $display("FAIL midrst_data got vals=%h idx=%0d want 0", vals, sample_idx); end
        n_checks++; if (vals_valid !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl got v=%b d=%b b=%b want 000", vals_valid, frame_done, busy); end
        tick();
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (vals_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_idle k=%0d got v=%b b=%b want 00", k, vals_valid, busy); end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        inc_count = 1'b0;
        n_checks++; if (vals_valid !== 1'b1 || sample_idx !== 4'd0) begin n_fail++; $display("FAIL midrst_restart got v=%b idx=%0d want v=1 idx=0", vals_valid, sample_idx); end
    endtask

    task automatic test_wrap();
        frame_len = 5'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        inc_count = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            n_checks++; if (vals_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid k=%0d got %b want 1", k, vals_valid); end
            n_checks++; if (sample_idx !== 4'(k % 3)) begin n_fail++; $display("FAIL wrap_idx k=%0d got %0d want %0d", k, sample_idx, k % 3); end
            n_checks++; if (frame_done !== (k % 3 == 2)) begin n_fail++; $display("FAIL wrap_done k=%0d got %b want %b", k, frame_done, (k % 3 == 2)); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wrap_busy k=%0d got %b want 1", k, busy); end
        end
        inc_count = 1'b0;
    endtask

    initial begin
        for (int c = 0; c < int'(NUM_CH); c++) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                dut.mem_q[c*DEPTH + i] = 16'((c << 12) | i);
            end
        end
        test_reset();
        test_basic();
`ifdef READRF_WRAP_EN
        test_wrap();
`else
        test_frame(4, 4, 10);
        test_frame(0, 16, 18);
        test_frame(20, 16, 18);
`endif
        test_restart();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
